// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game top-level sequencer with lives, score and speed levels
//
// Purpose: sequences INIT/START/GENFOOD/RENDER/MOVE/END (optionally PAUSE), keeps score, lives and
// speed level, and drives the control strobes for the food generator, snake datapath and renderer.
// Optional feature: define GAME_PAUSE_EN to build the PAUSE state (pause_btn toggles RENDER<->PAUSE).
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_start_btn      start request (level)
//   i_pause_btn      pause toggle pulse (only used with GAME_PAUSE_EN)
//   i_dir_in         requested direction: 00 up, 01 right, 10 down, 11 left
//   i_food_ack       food generator placed new food
//   i_render_done    renderer finished the current frame
//   i_eaten, i_dead  head hit food / wall-or-body during MOVE
//   o_clear          board clear (INIT)
//   o_rst_game       snake respawn pulse (START)
//   o_food_req       food request (GENFOOD)
//   o_flash          frame refresh (RENDER, PAUSE)
//   o_move_en        advance snake one cell (MOVE)
//   o_dir_out        committed direction
//   o_score          current score (saturating)
//   o_lives          remaining lives
//   o_level          current speed level
//   o_game_over      game over (END)
//   o_state_out      state encoding for debug display
module snake_game_ctrl #(
    parameter int SCORE_W     = 8,
    parameter int LIVES       = 3,
    parameter int LIVES_W     = 2,
    parameter int TICK_W      = 24,
    parameter int BASE_PERIOD = 5_000_000,
    parameter int PERIOD_STEP = 500_000,
    parameter int MIN_PERIOD  = 1_000_000,
    parameter int LEVEL_SCORE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start_btn,
    input  logic               i_pause_btn,
    input  logic [1:0]         i_dir_in,
    input  logic               i_food_ack,
    input  logic               i_render_done,
    input  logic               i_eaten,
    input  logic               i_dead,
    output logic               o_clear,
    output logic               o_rst_game,
    output logic               o_food_req,
    output logic               o_flash,
    output logic               o_move_en,
    output logic [1:0]         o_dir_out,
    output logic [SCORE_W-1:0] o_score,
    output logic [LIVES_W-1:0] o_lives,
    output logic [3:0]         o_level,
    output logic               o_game_over,
    output logic [2:0]         o_state_out
);

    typedef enum logic [2:0] {
        S_INIT    = 3'b000,
        S_START   = 3'b001,
        S_GENFOOD = 3'b010,
        S_RENDER  = 3'b011,
        S_MOVE    = 3'b100,
        S_END     = 3'b101,
        S_PAUSE   = 3'b110
    } state_t;

    localparam logic [TICK_W-1:0]  P_MIN   = TICK_W'(MIN_PERIOD);
    localparam logic [TICK_W-1:0]  P_BASE  = TICK_W'(BASE_PERIOD);
    localparam logic [LIVES_W-1:0] P_LIVES = LIVES_W'(LIVES);

    // level = score / LEVEL_SCORE, saturating at 15
    function automatic logic [3:0] f_level(input logic [SCORE_W-1:0] s);
        int q;
        q = int'(s) / LEVEL_SCORE;
        if (q > 15) return 4'd15;
        return q[3:0];
    endfunction

    // Clamp is decided before subtracting so the period never wraps below MIN_PERIOD.
    function automatic logic [TICK_W-1:0] f_period(input logic [3:0] lvl);
        logic [TICK_W+3:0] dec;
        dec = (TICK_W+4)'(lvl) * (TICK_W+4)'(PERIOD_STEP);
        if (BASE_PERIOD <= MIN_PERIOD) return P_MIN;
        if (dec >= (TICK_W+4)'(BASE_PERIOD - MIN_PERIOD)) return P_MIN;
        return P_BASE - dec[TICK_W-1:0];
    endfunction

    state_t             r_state;
    state_t             w_next;
    logic [TICK_W-1:0]  r_tick;
    logic [TICK_W-1:0]  r_period;
    logic               r_rd_seen;
    logic [1:0]         r_dir;
    logic [1:0]         r_dir_req;
    logic [SCORE_W-1:0] r_score;
    logic [LIVES_W-1:0] r_lives;
    logic [3:0]         r_level;
    logic               r_clear;
    logic               r_rst_game;
    logic               r_food_req;
    logic               r_flash;
    logic               r_move_en;
    logic               r_game_over;

    logic               w_rd_any;
    logic               w_tick_done;
    logic               w_enter_render;
    logic [1:0]         w_dir_sel;
    logic [SCORE_W-1:0] w_score_inc;
    logic [LIVES_W-1:0] w_lives_dec;

`ifndef GAME_PAUSE_EN
    logic w_unused_pause;
    assign w_unused_pause = i_pause_btn;
`endif

    // render_done counts if latched earlier in this RENDER visit or present right now
    assign w_rd_any    = r_rd_seen | ((r_state == S_RENDER) & i_render_done);
    assign w_tick_done = (r_tick >= (r_period - TICK_W'(1)));
    // Returning from PAUSE is a resume, not a fresh entry: tick and period are kept.
    assign w_enter_render = (w_next == S_RENDER) && (r_state != S_RENDER) && (r_state != S_PAUSE);
    // A reversal of the committed direction is dropped; the previous legal request stands.
    assign w_dir_sel   = (i_dir_in == (r_dir ^ 2'b10)) ? r_dir_req : i_dir_in;
    assign w_score_inc = (&r_score) ? r_score : r_score + SCORE_W'(1);
    assign w_lives_dec = r_lives - LIVES_W'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:    if (i_start_btn) w_next = S_START;
            S_START:   w_next = S_GENFOOD;
            S_GENFOOD: if (i_food_ack) w_next = S_RENDER;
            S_RENDER: begin
                if (w_tick_done && w_rd_any) w_next = S_MOVE;
`ifdef GAME_PAUSE_EN
                if (i_pause_btn) w_next = S_PAUSE;
`endif
            end
            S_MOVE: begin
                if (i_dead)       w_next = (w_lives_dec == '0) ? S_END : S_START;
                else if (i_eaten) w_next = S_GENFOOD;
                else              w_next = S_RENDER;
            end
            S_END:     if (i_start_btn) w_next = S_INIT;
`ifdef GAME_PAUSE_EN
            S_PAUSE:   if (i_pause_btn) w_next = S_RENDER;
`endif
            default:   w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_tick      <= '0;
            r_period    <= f_period(4'd0);
            r_rd_seen   <= 1'b0;
            r_dir       <= 2'b01;
            r_dir_req   <= 2'b01;
            r_score     <= '0;
            r_lives     <= P_LIVES;
            r_level     <= '0;
            r_clear     <= 1'b1;
            r_rst_game  <= 1'b0;
            r_food_req  <= 1'b0;
            r_flash     <= 1'b0;
            r_move_en   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == S_RENDER)  r_tick <= r_tick + TICK_W'(1);
            else if (w_enter_render) r_tick <= '0;

            // Speed changes only at the start of a new RENDER visit.
            if (w_enter_render) r_period <= f_period(r_level);

            if (w_next == S_RENDER || w_next == S_PAUSE) r_rd_seen <= w_rd_any;
            else                                         r_rd_seen <= 1'b0;

            if (r_state == S_INIT && i_start_btn)              r_dir <= 2'b01;
            else if (r_state == S_RENDER && w_next == S_MOVE)  r_dir <= w_dir_sel;

            if (r_state == S_RENDER)     r_dir_req <= w_dir_sel;
            else if (r_state != S_PAUSE) r_dir_req <= r_dir;

            if (r_state == S_INIT && i_start_btn) begin
                r_score <= '0;
                r_lives <= P_LIVES;
                r_level <= '0;
            end else if (r_state == S_MOVE) begin
                if (i_dead) begin
                    r_lives <= w_lives_dec;
                end else if (i_eaten) begin
                    r_score <= w_score_inc;
                    r_level <= f_level(w_score_inc);
                end
            end

            r_clear     <= (w_next == S_INIT);
            r_rst_game  <= (w_next == S_START);
            r_food_req  <= (w_next == S_GENFOOD);
            r_flash     <= (w_next == S_RENDER) || (w_next == S_PAUSE);
            r_move_en   <= (w_next == S_MOVE);
            r_game_over <= (w_next == S_END);
        end
    end

    assign o_clear     = r_clear;
    assign o_rst_game  = r_rst_game;
    assign o_food_req  = r_food_req;
    assign o_flash     = r_flash;
    assign o_move_en   = r_move_en;
    assign o_game_over = r_game_over;
    assign o_dir_out   = r_dir;
    assign o_score     = r_score;
    assign o_lives     = r_lives;
    assign o_level     = r_level;
    assign o_state_out = r_state;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - directed self-checking bench for snake_game_ctrl
module tb_snake_game_ctrl;

    localparam int SCORE_W     = 8;
    localparam int LIVES_W     = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start_btn = 1'b0;
    logic               pause_btn = 1'b0;
    logic [1:0]         dir_in = 2'b01;
    logic               food_ack = 1'b0;
    logic               render_done = 1'b0;
    logic               eaten = 1'b0;
    logic               dead = 1'b0;
    logic               clear, rst_game, food_req, flash, move_en, game_over;
    logic [1:0]         dir_out;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives;
    logic [3:0]         level;
    logic [2:0]         state_out;

    int n_checks = 0;
    int n_fail   = 0;

    snake_game_ctrl #(
        .SCORE_W(8), .LIVES(3), .LIVES_W(2), .TICK_W(24),
        .BASE_PERIOD(10), .PERIOD_STEP(2), .MIN_PERIOD(4), .LEVEL_SCORE(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_start_btn(start_btn), .i_pause_btn(pause_btn), .i_dir_in(dir_in),
        .i_food_ack(food_ack), .i_render_done(render_done), .i_eaten(eaten), .i_dead(dead),
        .o_clear(clear), .o_rst_game(rst_game), .o_food_req(food_req), .o_flash(flash),
        .o_move_en(move_en), .o_dir_out(dir_out), .o_score(score), .o_lives(lives),
        .o_level(level), .o_game_over(game_over), .o_state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From RENDER entry: hold render_done, wait for MOVE, apply eat/die, leave MOVE.
    task automatic one_move(input logic eat, input logic die, output int n);
        n = 0;
        render_done = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            n++;
            if (move_en) break;
        end
        render_done = 1'b0;
        eaten = eat;
        dead  = die;
        step();
        eaten = 1'b0;
        dead  = 1'b0;
    endtask

    task automatic ack_food();
        food_ack = 1'b1;
        step();
        food_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_out); end
        n_checks++; if (clear !== 1'b1) begin n_fail++; $display("FAIL reset_clear: got %0d expected 1", clear); end
        n_checks++; if ({rst_game, food_req, flash, move_en, game_over} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00000", {rst_game, food_req, flash, move_en, game_over}); end
        n_checks++; if (score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
        n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives: got %0d expected 3", lives); end
        n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if (dir_out !== 2'b01) begin n_fail++; $display("FAIL reset_dir: got %0d expected 1", dir_out); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_start();
        start_btn = 1'b1;
        step();
        n_checks++; if (state_out !== 3'd1) begin n_fail++; $display("FAIL start_state: got %0d expected 1", state_out); end
        n_checks++; if (rst_game !== 1'b1) begin n_fail++; $display("FAIL start_rst_game: got %0d expected 1", rst_game); end
        n_checks++; if (clear !== 1'b0) begin n_fail++; $display("FAIL start_clear: got %0d expected 0", clear); end
        start_btn = 1'b0;
        step();
        n_checks++; if (state_out !== 3'd2) begin n_fail++; $display("FAIL genfood_state: got %0d expected 2", state_out); end
        n_checks++; if (food_req !== 1'b1) begin n_fail++; $display("FAIL genfood_req: got %0d expected 1", food_req); end
        n_checks++; if (rst_game !== 1'b0) begin n_fail++; $display("FAIL rst_game_pulse: got %0d expected 0", rst_game); end
        repeat (3) step();
        n_checks++; if (food_req !== 1'b1) begin n_fail++; $display("FAIL food_req_hold: got %0d expected 1", food_req); end
        ack_food();
        n_checks++; if (state_out !== 3'd3) begin n_fail++; $display("FAIL render_state: got %0d expected 3", state_out); end
        n_checks++; if ({food_req, flash} !== 2'b01) begin n_fail++; $display("FAIL render_strobes: got %b expected 01", {food_req, flash}); end
    endtask

    task automatic test_period();
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            render_done = (n == 3);
            step();
            n++;
            if (move_en) break;
        end
        render_done = 1'b0;
        n_checks++; if (n !== 10) begin n_fail++; $display("FAIL period_latency: got %0d expected 10", n); end
        step();
        n_checks++; if ({move_en, state_out} !== {1'b0, 3'd3}) begin n_fail++; $display("FAIL move_pulse: got %b expected 0011", {move_en, state_out}); end
        // render_done arriving after the period expires gates the move
        n = 0;
        for (int i = 0; i < 100; i++) begin
            render_done = (n == 12);
            step();
            n++;
            if (move_en) break;
        end
        render_done = 1'b0;
        n_checks++; if (n !== 13) begin n_fail++; $display("FAIL late_render_done: got %0d expected 13", n); end
        step();
    endtask

    task automatic test_direction();
        int n;
        dir_in = 2'b11;
        step();
        step();
        dir_in = 2'b00;
        one_move(1'b0, 1'b0, n);
        n_checks++; if (dir_out !== 2'b00) begin n_fail++; $display("FAIL dir_last_legal: got %0d expected 0", dir_out); end
        dir_in = 2'b01;
        one_move(1'b0, 1'b0, n);
        n_checks++; if (dir_out !== 2'b01) begin n_fail++; $display("FAIL dir_turn_right: got %0d expected 1", dir_out); end
        dir_in = 2'b11;
        one_move(1'b0, 1'b0, n);
        n_checks++; if (dir_out !== 2'b01) begin n_fail++; $display("FAIL dir_reverse_ignored: got %0d expected 1", dir_out); end
        dir_in = 2'b01;
    endtask

    task automatic test_score_level();
        int n;
        for (int i = 0; i < 7; i++) begin
            one_move(1'b1, 1'b0, n);
            ack_food();
        end
        n_checks++; if ({score, level} !== {8'd7, 4'd0}) begin n_fail++; $display("FAIL score7: got score %0d level %0d expected 7 0", score, level); end
        one_move(1'b1, 1'b0, n);
        ack_food();
        n_checks++; if ({score, level} !== {8'd8, 4'd1}) begin n_fail++; $display("FAIL score8: got score %0d level %0d expected 8 1", score, level); end
        one_move(1'b0, 1'b0, n);
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL period_level1: got %0d expected 8", n); end
        for (int i = 0; i < 247; i++) begin
            one_move(1'b1, 1'b0, n);
            ack_food();
        end
        n_checks++; if ({score, level} !== {8'd255, 4'd15}) begin n_fail++; $display("FAIL score255: got score %0d level %0d expected 255 15", score, level); end
        one_move(1'b0, 1'b0, n);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL period_floor: got %0d expected 4", n); end
        one_move(1'b1, 1'b0, n);
        n_checks++; if (score !== 8'd255) begin n_fail++; $display("FAIL score_saturate: got %0d expected 255", score); end
        ack_food();
    endtask

    task automatic test_lives();
        int n;
        dir_in = 2'b00;
        one_move(1'b1, 1'b1, n);
        n_checks++; if ({state_out, lives} !== {3'd1, 2'd2}) begin n_fail++; $display("FAIL death1: got state %0d lives %0d expected 1 2", state_out, lives); end
        n_checks++; if (score !== 8'd255) begin n_fail++; $display("FAIL death_keeps_score: got %0d expected 255", score); end
        n_checks++; if (rst_game !== 1'b1) begin n_fail++; $display("FAIL respawn_pulse: got %0d expected 1", rst_game); end
        step();
        ack_food();
        one_move(1'b0, 1'b1, n);
        n_checks++; if ({state_out, lives} !== {3'd1, 2'd1}) begin n_fail++; $display("FAIL death2: got state %0d lives %0d expected 1 1", state_out, lives); end
        step();
        ack_food();
        one_move(1'b0, 1'b1, n);
        n_checks++; if ({state_out, lives, game_over} !== {3'd5, 2'd0, 1'b1}) begin n_fail++; $display("FAIL death3: got state %0d lives %0d over %0d expected 5 0 1", state_out, lives, game_over); end
        step();
        n_checks++; if (state_out !== 3'd5) begin n_fail++; $display("FAIL end_hold: got %0d expected 5", state_out); end
        start_btn = 1'b1;
        step();
        n_checks++; if ({state_out, clear, game_over} !== {3'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL end_to_init: got state %0d clear %0d over %0d expected 0 1 0", state_out, clear, game_over); end
        step();
        n_checks++; if ({state_out, score, lives, level, dir_out} !== {3'd1, 8'd0, 2'd3, 4'd0, 2'b01}) begin n_fail++; $display("FAIL restart: got state %0d score %0d lives %0d level %0d dir %0d expected 1 0 3 0 1", state_out, score, lives, level, dir_out); end
        start_btn = 1'b0;
        dir_in = 2'b01;
    endtask

    task automatic test_mid_reset();
        int n;
        step();
        ack_food();
        one_move(1'b1, 1'b0, n);
        n_checks++; if ({food_req, score} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL pre_reset: got req %0d score %0d expected 1 1", food_req, score); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({state_out, food_req, clear, score, lives} !== {3'd0, 1'b0, 1'b1, 8'd0, 2'd3}) begin n_fail++; $display("FAIL mid_reset: got state %0d req %0d clear %0d score %0d lives %0d expected 0 0 1 0 3", state_out, food_req, clear, score, lives); end
        step();
        rst_n = 1'b1;
        step();
    endtask

`ifdef GAME_PAUSE_EN
    task automatic test_pause();
        int n;
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        step();
        ack_food();
        render_done = 1'b1;
        repeat (4) step();
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        n_checks++; if ({state_out, flash} !== {3'd6, 1'b1}) begin n_fail++; $display("FAIL pause_enter: got state %0d flash %0d expected 6 1", state_out, flash); end
        repeat (50) step();
        n_checks++; if ({state_out, move_en} !== {3'd6, 1'b0}) begin n_fail++; $display("FAIL pause_hold: got state %0d move %0d expected 6 0", state_out, move_en); end
        pause_btn = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            pause_btn = 1'b0;
            n++;
            if (move_en) break;
        end
        render_done = 1'b0;
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL pause_resume: got %0d expected 6", n); end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_period();
        test_direction();
        test_score_level();
        test_lives();
        test_mid_reset();
`ifdef GAME_PAUSE_EN
        test_pause();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
